// File: rtl/pack_record_fifo.sv
// rtl/pack_record_fifo.sv - FIFO of packed a/b/c/colour records with masked default fill
module pack_record_fifo #(
    parameter int         A_W          = 32,
    parameter int         B_W          = 16,
    parameter int         C_W          = 8,
    parameter int         DEPTH        = 4,
    parameter logic [7:0] DEFAULT_FILL = 8'h05
) (
    input  logic                       i_clk,
    input  logic                       i_arst,
    input  logic                       i_wr_valid,
    output logic                       o_wr_ready,
    input  logic [2:0]                 i_wr_mask,
    input  logic [A_W-1:0]             i_wr_a,
    input  logic [B_W-1:0]             i_wr_b,
    input  logic [C_W-1:0]             i_wr_c,
    input  logic [2:0]                 i_wr_color,
    output logic                       o_rd_valid,
    input  logic                       i_rd_ready,
    output logic [A_W-1:0]             o_rd_a,
    output logic [B_W-1:0]             o_rd_b,
    output logic [C_W-1:0]             o_rd_c,
    output logic [2:0]                 o_rd_color,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_err_color
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [A_W-1:0] FILL_A = {(A_W/8){DEFAULT_FILL}};
    localparam logic [B_W-1:0] FILL_B = {(B_W/8){DEFAULT_FILL}};
    localparam logic [C_W-1:0] FILL_C = {(C_W/8){DEFAULT_FILL}};

    typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;
    typedef enum logic [2:0] {
        RED = 3'd0, GREEN = 3'd1, BLUE = 3'd2, YELLOW = 3'd3, WHITE = 3'd4, BLACK = 3'd5
    } color_t;

    state_t          state, state_nx;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW-1:0]   wr_ptr_inc, rd_ptr_inc;
    logic [A_W-1:0]  mem_a     [DEPTH];
    logic [B_W-1:0]  mem_b     [DEPTH];
    logic [C_W-1:0]  mem_c     [DEPTH];
    color_t          mem_color [DEPTH];
    logic            push, pop;
    logic            color_bad;
    logic [A_W-1:0]  wr_a_f;
    logic [B_W-1:0]  wr_b_f;
    logic [C_W-1:0]  wr_c_f;
    color_t          wr_color_f;

    assign o_wr_ready = (state != S_FULL);
    assign o_rd_valid = (state != S_EMPTY);
    assign push       = i_wr_valid & o_wr_ready;
    assign pop        = o_rd_valid & i_rd_ready;
    assign wr_ptr_inc = wr_ptr + PW'(1);
    assign rd_ptr_inc = rd_ptr + PW'(1);

    // Masked-off fields take the replicated fill byte; colour is never masked
    assign color_bad  = (i_wr_color > 3'd5);
    assign wr_a_f     = i_wr_mask[2] ? i_wr_a : FILL_A;
    assign wr_b_f     = i_wr_mask[1] ? i_wr_b : FILL_B;
    assign wr_c_f     = i_wr_mask[0] ? i_wr_c : FILL_C;
    assign wr_color_f = color_bad ? RED : color_t'(i_wr_color);

    assign o_rd_a     = mem_a[rd_ptr];
    assign o_rd_b     = mem_b[rd_ptr];
    assign o_rd_c     = mem_c[rd_ptr];
    assign o_rd_color = mem_color[rd_ptr];

    // Equal pointers are ambiguous, so FULL is resolved from the FSM state
    assign o_count = (state == S_FULL) ? CW'(DEPTH) : {1'b0, wr_ptr - rd_ptr};

    always_comb begin
        state_nx = state;
        case (state)
            S_EMPTY: begin
                if (push) state_nx = S_PARTIAL;
            end
            S_PARTIAL: begin
                if (push && !pop && (wr_ptr_inc == rd_ptr)) state_nx = S_FULL;
                else if (pop && !push && (rd_ptr_inc == wr_ptr)) state_nx = S_EMPTY;
            end
            S_FULL: begin
                if (pop) state_nx = S_PARTIAL;
            end
            default: state_nx = S_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state       <= S_EMPTY;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_err_color <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i]     <= FILL_A;
                mem_b[i]     <= FILL_B;
                mem_c[i]     <= FILL_C;
                mem_color[i] <= RED;
            end
        end else begin
            state       <= state_nx;
            o_err_color <= push & color_bad;
            if (push) begin
                mem_a[wr_ptr]     <= wr_a_f;
                mem_b[wr_ptr]     <= wr_b_f;
                mem_c[wr_ptr]     <= wr_c_f;
                mem_color[wr_ptr] <= wr_color_f;
                wr_ptr            <= wr_ptr_inc;
            end
            if (pop) rd_ptr <= rd_ptr_inc;
        end
    end
endmodule

// File: doc/pack_record_fifo.md
# pack_record_fifo

Parametrised FIFO of packed records, each holding three integer fields plus a six-value colour enum tag. Producers may write any subset of the fields; unwritten fields take a replicated default byte, the hardware equivalent of a `'{a: .., default: ..}` assignment pattern. Sits between record producers and consumers in the package-typed datapath. Valid/ready handshake on both sides, explicit occupancy FSM, illegal-enum scrubbing.

## Interface

- A_W, 32, width of field a (multiple of 8, ≥8)
- B_W, 16, width of field b (multiple of 8, ≥8)
- C_W, 8, width of field c (multiple of 8, ≥8)
- DEPTH, 4, entry count (power of 2, ≥2)
- DEFAULT_FILL, 8'h05, byte replicated into masked-off fields and reset contents

Ports:

- i_clk  in  1  clock; all state on rising edge
- i_arst  in  1  reset, asynchronous, active-high
- i_wr_valid  in  1  write request
- o_wr_ready  out  1  FIFO can accept; high iff state ≠ FULL
- i_wr_mask  in  3  field enables [2]=a [1]=b [0]=c; 0 → field = DEFAULT_FILL replicated
- i_wr_a / i_wr_b / i_wr_c  in  A_W / B_W / C_W  field data
- i_wr_color  in  3  colour tag: red=0 green=1 blue=2 yellow=3 white=4 black=5
- o_rd_valid  out  1  head entry present; high iff state ≠ EMPTY
- i_rd_ready  in  1  consumer accepts head
- o_rd_a / o_rd_b / o_rd_c / o_rd_color  out  A_W / B_W / C_W / 3  head entry fields
- o_count  out  $clog2(DEPTH)+1  occupancy
- o_err_color  out  1  one-cycle pulse: accepted write carried colour 6 or 7

## Operation

- Push = i_wr_valid & o_wr_ready; pop = o_rd_valid & i_rd_ready.
- On push, entry stored at wr_ptr: each field = input if mask bit set, else {N{DEFAULT_FILL}}; colour 6/7 stored as red and o_err_color pulses next cycle. Colour is never masked.
- On pop, rd_ptr advances; o_rd_* read combinationally from mem[rd_ptr].
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH without special handling.
- FSM states EMPTY, PARTIAL, FULL (one-hot or binary, implementer's choice):
  - EMPTY: push → PARTIAL (or FULL if DEPTH were 1, unsupported). Pop impossible.
  - PARTIAL: push only → count+1, FULL when count reaches DEPTH; pop only → count−1, EMPTY at 0; both → count, state unchanged, both pointers advance.
  - FULL: push refused (o_wr_ready=0, no pass-through); pop → PARTIAL.
- i_wr_valid while FULL: data dropped, no state change, no error pulse.
- o_count equals wr_ptr − rd_ptr, with DEPTH in FULL; it must agree with the FSM at all times.

## Timing

- Reset (async assert, released synchronously by the environment): state EMPTY, pointers 0, o_count 0, o_wr_ready 1, o_rd_valid 0, o_err_color 0.
- All mem entries reset to a/b/c = replicated DEFAULT_FILL, colour red, so o_rd_* = 32'h05050505 / 16'h0505 / 8'h05 / 0 at default parameters.
- Write-to-read latency 1 cycle. Data pushed at edge k appears on o_rd_* with o_rd_valid=1 after edge k when the FIFO was empty.
- o_wr_ready and o_rd_valid are decoded from registered state only, with no combinational path from i_rd_ready or i_wr_valid.
- o_err_color is registered: high exactly the cycle after the accepting edge.
- Reset mid-operation discards all entries immediately, and outputs take reset values asynchronously.

## Test plan

- Reset, then idle: o_wr_ready=1, o_rd_valid=0, o_count=0, o_rd_a=32'h05050505, o_rd_color=0.
- One push, mask=3'b110, a=1, b=2, c=3, colour=5: next cycle o_rd_valid=1, a=1, b=2, c=8'h05, colour=5, o_count=1. Pop returns to EMPTY.
- Push 4 entries back-to-back with i_rd_ready=0: o_count=4, o_wr_ready=0. A 5th push is dropped. Pops return all 4 in order, and pointers wrap correctly over a further 6 push/pop cycles.
- With count=2, assert push and pop together for 10 cycles: o_count stays 2, and output order is preserved.
- Push colour=7, mask=3'b111: stored colour 0, o_err_color=1 for exactly one cycle. Colour 7 offered while FULL gives no pulse.
- Fill 3 entries, assert i_arst mid-cycle: outputs return to reset values before the next edge, and the first push after release reads back correctly.
